// File: rtl/execute_stage.sv
// EX stage of the MiniRISC-V pipeline: operand forwarding, ALU, iterative shift-add MUL and the
// EX/MEM pipeline register. ex_stall holds upstream while a multiply is in flight.
module execute_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ID_EX_valid,
  input  logic [XLEN-1:0] ID_EX_rs1data,
  input  logic [XLEN-1:0] ID_EX_rs2data,
  input  logic [XLEN-1:0] ID_EX_imm,
  input  logic [4:0]      ID_EX_rs1,
  input  logic [4:0]      ID_EX_rs2,
  input  logic [4:0]      ID_EX_rd,
  input  logic            ID_EX_alusrc,
  input  logic [3:0]      ID_EX_aluop,
  input  logic            ID_EX_regwrite,
  input  logic            ID_EX_memread,
  input  logic            ID_EX_memwrite,
  input  logic            MEM_WB_regwrite,
  input  logic [4:0]      MEM_WB_rd,
  input  logic [XLEN-1:0] MEM_WB_wbdata,
  input  logic            flush,
  output logic [XLEN-1:0] EX_MEM_alures,
  output logic [XLEN-1:0] EX_MEM_alusec,
  output logic            EX_MEM_regwrite,
  output logic            EX_MEM_memread,
  output logic            EX_MEM_memwrite,
  output logic [4:0]      EX_MEM_rd,
  output logic            ex_stall
);

  localparam int unsigned CntW = $clog2(MUL_CYCLES);
  localparam int unsigned ShW  = $clog2(XLEN);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpSll  = 4'd5;
  localparam logic [3:0] OpSrl  = 4'd6;
  localparam logic [3:0] OpSra  = 4'd7;
  localparam logic [3:0] OpSlt  = 4'd8;
  localparam logic [3:0] OpSltu = 4'd9;
  localparam logic [3:0] OpMul  = 4'd10;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [4:0]        mul_rd_q, mul_rd_d;
  logic              mul_rw_q, mul_rw_d;

  logic [XLEN-1:0]   fwd_a, fwd_b, op_b, alu_res;
  logic [XLEN-1:0]   partial, acc_sum;
  logic              last_step;

  logic [XLEN-1:0]   alures_d, alusec_d;
  logic              regwrite_d, memread_d, memwrite_d;
  logic [4:0]        rd_d;

  // EX/MEM beats MEM/WB; loads in EX/MEM are not ready yet and x0 is never forwarded.
  always_comb begin
    if (EX_MEM_regwrite && !EX_MEM_memread && EX_MEM_rd != 5'd0 && EX_MEM_rd == ID_EX_rs1) begin
      fwd_a = EX_MEM_alures;
    end else if (MEM_WB_regwrite && MEM_WB_rd != 5'd0 && MEM_WB_rd == ID_EX_rs1) begin
      fwd_a = MEM_WB_wbdata;
    end else begin
      fwd_a = ID_EX_rs1data;
    end
    if (EX_MEM_regwrite && !EX_MEM_memread && EX_MEM_rd != 5'd0 && EX_MEM_rd == ID_EX_rs2) begin
      fwd_b = EX_MEM_alures;
    end else if (MEM_WB_regwrite && MEM_WB_rd != 5'd0 && MEM_WB_rd == ID_EX_rs2) begin
      fwd_b = MEM_WB_wbdata;
    end else begin
      fwd_b = ID_EX_rs2data;
    end
    op_b = ID_EX_alusrc ? ID_EX_imm : fwd_b;
  end

  always_comb begin
    alu_res = '0;
    case (ID_EX_aluop)
      OpAdd:   alu_res = fwd_a + op_b;
      OpSub:   alu_res = fwd_a - op_b;
      OpAnd:   alu_res = fwd_a & op_b;
      OpOr:    alu_res = fwd_a | op_b;
      OpXor:   alu_res = fwd_a ^ op_b;
      OpSll:   alu_res = fwd_a << op_b[ShW-1:0];
      OpSrl:   alu_res = fwd_a >> op_b[ShW-1:0];
      OpSra:   alu_res = $unsigned($signed(fwd_a) >>> op_b[ShW-1:0]);
      OpSlt:   alu_res = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
      OpSltu:  alu_res = {{(XLEN-1){1'b0}}, fwd_a < op_b};
      default: alu_res = '0;
    endcase
  end

  assign partial   = mplier_q[count_q] ? (mcand_q << count_q) : '0;
  assign acc_sum   = acc_q + partial;
  assign last_step = (count_q == CntW'(MUL_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    count_d    = count_q;
    mul_rd_d   = mul_rd_q;
    mul_rw_d   = mul_rw_q;
    ex_stall   = 1'b0;
    alures_d   = '0;
    alusec_d   = '0;
    regwrite_d = 1'b0;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    rd_d       = 5'd0;
    unique case (state_q)
      StIdle: begin
        if (!flush && ID_EX_valid) begin
          if (ID_EX_aluop == OpMul) begin
            ex_stall = 1'b1;
            state_d  = StBusy;
            mcand_d  = fwd_a;
            mplier_d = op_b;
            acc_d    = '0;
            count_d  = '0;
            mul_rd_d = ID_EX_rd;
            mul_rw_d = ID_EX_regwrite;
          end else begin
            alures_d   = alu_res;
            alusec_d   = fwd_b;
            regwrite_d = ID_EX_regwrite;
            memread_d  = ID_EX_memread;
            memwrite_d = ID_EX_memwrite;
            rd_d       = ID_EX_rd;
          end
        end
      end
      StBusy: begin
        // Stall drops in the final step so upstream advances on the completion edge.
        ex_stall = !last_step;
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d   = acc_sum;
          count_d = count_q + CntW'(1);
          if (last_step) begin
            state_d    = StIdle;
            alures_d   = acc_sum;
            regwrite_d = mul_rw_q;
            rd_d       = mul_rd_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      mcand_q         <= '0;
      mplier_q        <= '0;
      acc_q           <= '0;
      count_q         <= '0;
      mul_rd_q        <= 5'd0;
      mul_rw_q        <= 1'b0;
      EX_MEM_alures   <= '0;
      EX_MEM_alusec   <= '0;
      EX_MEM_regwrite <= 1'b0;
      EX_MEM_memread  <= 1'b0;
      EX_MEM_memwrite <= 1'b0;
      EX_MEM_rd       <= 5'd0;
    end else begin
      state_q         <= state_d;
      mcand_q         <= mcand_d;
      mplier_q        <= mplier_d;
      acc_q           <= acc_d;
      count_q         <= count_d;
      mul_rd_q        <= mul_rd_d;
      mul_rw_q        <= mul_rw_d;
      EX_MEM_alures   <= alures_d;
      EX_MEM_alusec   <= alusec_d;
      EX_MEM_regwrite <= regwrite_d;
      EX_MEM_memread  <= memread_d;
      EX_MEM_memwrite <= memwrite_d;
      EX_MEM_rd       <= rd_d;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: forwarding, ALU ops, iterative MUL timing, flush and reset.
module tb_execute_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ID_EX_valid;
  logic [31:0] ID_EX_rs1data, ID_EX_rs2data, ID_EX_imm;
  logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
  logic        ID_EX_alusrc;
  logic [3:0]  ID_EX_aluop;
  logic        ID_EX_regwrite, ID_EX_memread, ID_EX_memwrite;
  logic        MEM_WB_regwrite;
  logic [4:0]  MEM_WB_rd;
  logic [31:0] MEM_WB_wbdata;
  logic        flush;
  logic [31:0] EX_MEM_alures, EX_MEM_alusec;
  logic        EX_MEM_regwrite, EX_MEM_memread, EX_MEM_memwrite;
  logic [4:0]  EX_MEM_rd;
  logic        ex_stall;

  int checks = 0;
  int errors = 0;

  execute_stage #(.XLEN(32), .MUL_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_EX_valid(ID_EX_valid), .ID_EX_rs1data(ID_EX_rs1data), .ID_EX_rs2data(ID_EX_rs2data),
    .ID_EX_imm(ID_EX_imm), .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
    .ID_EX_alusrc(ID_EX_alusrc), .ID_EX_aluop(ID_EX_aluop), .ID_EX_regwrite(ID_EX_regwrite),
    .ID_EX_memread(ID_EX_memread), .ID_EX_memwrite(ID_EX_memwrite),
    .MEM_WB_regwrite(MEM_WB_regwrite), .MEM_WB_rd(MEM_WB_rd), .MEM_WB_wbdata(MEM_WB_wbdata),
    .flush(flush), .EX_MEM_alures(EX_MEM_alures), .EX_MEM_alusec(EX_MEM_alusec),
    .EX_MEM_regwrite(EX_MEM_regwrite), .EX_MEM_memread(EX_MEM_memread),
    .EX_MEM_memwrite(EX_MEM_memwrite), .EX_MEM_rd(EX_MEM_rd), .ex_stall(ex_stall)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] im, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic src, input logic [3:0] op,
                       input logic rw, input logic mr, input logic mw);
    ID_EX_valid = v; ID_EX_rs1data = d1; ID_EX_rs2data = d2; ID_EX_imm = im;
    ID_EX_rs1 = r1; ID_EX_rs2 = r2; ID_EX_rd = rd; ID_EX_alusrc = src; ID_EX_aluop = op;
    ID_EX_regwrite = rw; ID_EX_memread = mr; ID_EX_memwrite = mw;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (EX_MEM_alures !== 32'h0) begin
      errors++; $display("FAIL reset_alures: got %h want 0", EX_MEM_alures);
    end
    checks++;
    if ({EX_MEM_regwrite, EX_MEM_memread, EX_MEM_memwrite, EX_MEM_rd} !== 8'h0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0",
                         {EX_MEM_regwrite, EX_MEM_memread, EX_MEM_memwrite, EX_MEM_rd});
    end
    checks++;
    if (ex_stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b want 0", ex_stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    drive(1, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 0, 4'd0, 1, 0, 0);
    step();
    checks++;
    if (EX_MEM_alures !== 32'd12) begin
      errors++; $display("FAIL add_res: got %h want 0000000c", EX_MEM_alures);
    end
    checks++;
    if (EX_MEM_rd !== 5'd3 || EX_MEM_regwrite !== 1'b1) begin
      errors++; $display("FAIL add_ctrl: got rd=%0d rw=%b want rd=3 rw=1", EX_MEM_rd,
                         EX_MEM_regwrite);
    end
    checks++;
    if (EX_MEM_alusec !== 32'd7) begin
      errors++; $display("FAIL add_alusec: got %h want 00000007", EX_MEM_alusec);
    end
  endtask

  task automatic test_forward();
    logic [31:0] exp_tab [3];
    logic [4:0]  rd_tab [3];
    logic        mr_tab [3];
    exp_tab = '{32'h11, 32'h21, 32'h56};
    rd_tab  = '{5'd4, 5'd4, 5'd0};
    mr_tab  = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      MEM_WB_regwrite = 1'b0;
      // Producer lands in EX/MEM: alures=0x10, rd per case
      drive(1, 32'h10, 32'h0, 32'h0, 5'd0, 5'd0, rd_tab[i], 0, 4'd0, 1, mr_tab[i], 0);
      step();
      MEM_WB_regwrite = 1'b1; MEM_WB_rd = rd_tab[i]; MEM_WB_wbdata = 32'h20;
      drive(1, 32'h55, 32'h1, 32'h0, rd_tab[i], 5'd0, 5'd9, 0, 4'd0, 1, 0, 0);
      step();
      checks++;
      if (EX_MEM_alures !== exp_tab[i]) begin
        errors++; $display("FAIL forward_case%0d: got %h want %h", i, EX_MEM_alures, exp_tab[i]);
      end
    end
    MEM_WB_regwrite = 1'b0;
  endtask

  task automatic test_store();
    MEM_WB_regwrite = 1'b1; MEM_WB_rd = 5'd5; MEM_WB_wbdata = 32'hDEADBEEF;
    drive(1, 32'h0, 32'h0, 32'h100, 5'd0, 5'd5, 5'd0, 1, 4'd0, 0, 0, 1);
    step();
    MEM_WB_regwrite = 1'b0;
    checks++;
    if (EX_MEM_alures !== 32'h100) begin
      errors++; $display("FAIL store_addr: got %h want 00000100", EX_MEM_alures);
    end
    checks++;
    if (EX_MEM_alusec !== 32'hDEADBEEF) begin
      errors++; $display("FAIL store_data: got %h want deadbeef", EX_MEM_alusec);
    end
    checks++;
    if (EX_MEM_memwrite !== 1'b1 || EX_MEM_regwrite !== 1'b0) begin
      errors++; $display("FAIL store_ctrl: got mw=%b rw=%b want mw=1 rw=0", EX_MEM_memwrite,
                         EX_MEM_regwrite);
    end
  endtask

  task automatic test_alu();
    logic [31:0] a_tab [6];
    logic [31:0] b_tab [6];
    logic [3:0]  op_tab [6];
    logic [31:0] exp_tab [6];
    a_tab   = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3, 32'h1, 32'h0F0F00FF};
    b_tab   = '{32'd4, 32'd1, 32'd1, 32'd5, 32'h21, 32'hFF0F0F0F};
    op_tab  = '{4'd7, 4'd8, 4'd9, 4'd1, 4'd5, 4'd4};
    // SLL by 0x21 uses only b[4:0] = 1
    exp_tab = '{32'hF8000000, 32'd1, 32'd0, 32'hFFFFFFFE, 32'h2, 32'hF0000FF0};
    for (int i = 0; i < 6; i++) begin
      drive(1, a_tab[i], 32'h0, b_tab[i], 5'd0, 5'd0, 5'd6, 1, op_tab[i], 1, 0, 0);
      step();
      checks++;
      if (EX_MEM_alures !== exp_tab[i]) begin
        errors++; $display("FAIL alu_op%0d: got %h want %h", op_tab[i], EX_MEM_alures, exp_tab[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int stalls;
    int bad;
    drive(1, 32'hFFFFFFFF, 32'd3, 32'h0, 5'd0, 5'd0, 5'd7, 0, 4'd10, 1, 0, 0);
    #1;
    for (int m = 0; m < 2; m++) begin
      stalls = 0; bad = 0;
      while (ex_stall === 1'b1 && stalls < 40) begin
        stalls++;
        step();
        if (EX_MEM_regwrite !== 1'b0 || EX_MEM_alures !== 32'h0) bad++;
      end
      checks++;
      if (stalls != 32) begin
        errors++; $display("FAIL mul%0d_stall_len: got %0d want 32", m, stalls);
      end
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL mul%0d_bubbles: got %0d non-bubbles want 0", m, bad);
      end
      if (m == 0) drive(1, 32'd6, 32'd7, 32'h0, 5'd0, 5'd0, 5'd8, 0, 4'd10, 1, 0, 0);
      else drive(0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 4'd0, 0, 0, 0);
      step();
      checks++;
      if (EX_MEM_alures !== (m == 0 ? 32'hFFFFFFFD : 32'd42)) begin
        errors++; $display("FAIL mul%0d_product: got %h want %h", m, EX_MEM_alures,
                           (m == 0 ? 32'hFFFFFFFD : 32'd42));
      end
      checks++;
      if (EX_MEM_regwrite !== 1'b1 || EX_MEM_rd !== (m == 0 ? 5'd7 : 5'd8)) begin
        errors++; $display("FAIL mul%0d_ctrl: got rw=%b rd=%0d", m, EX_MEM_regwrite, EX_MEM_rd);
      end
      if (m == 0) begin
        checks++;
        if (ex_stall !== 1'b1) begin
          errors++; $display("FAIL mul_reissue_stall: got %b want 1", ex_stall);
        end
      end
    end
  endtask

  task automatic test_flush();
    int bad;
    drive(1, 32'd9, 32'd9, 32'h0, 5'd0, 5'd0, 5'd3, 0, 4'd0, 1, 0, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (EX_MEM_regwrite !== 1'b0 || EX_MEM_alures !== 32'h0) begin
      errors++; $display("FAIL flush_alu: got rw=%b res=%h want bubble", EX_MEM_regwrite,
                         EX_MEM_alures);
    end
    drive(1, 32'd5, 32'd5, 32'h0, 5'd0, 5'd0, 5'd12, 0, 4'd10, 1, 0, 0);
    for (int i = 0; i < 11; i++) step();
    flush = 1'b1;
    drive(0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 4'd0, 0, 0, 0);
    step();
    flush = 1'b0;
    checks++;
    if (ex_stall !== 1'b0) begin
      errors++; $display("FAIL flush_mul_stall: got %b want 0", ex_stall);
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (EX_MEM_regwrite !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL flush_mul_writeback: got %0d writes want 0", bad);
    end
  endtask

  task automatic test_reset_mid_mul();
    int bad;
    drive(1, 32'd5, 32'd5, 32'h0, 5'd0, 5'd0, 5'd13, 0, 4'd10, 1, 0, 0);
    for (int i = 0; i < 21; i++) step();
    drive(0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 4'd0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ex_stall !== 1'b0 || EX_MEM_regwrite !== 1'b0 || EX_MEM_rd !== 5'd0) begin
      errors++; $display("FAIL reset_mid_mul: got stall=%b rw=%b rd=%0d want 0", ex_stall,
                         EX_MEM_regwrite, EX_MEM_rd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (EX_MEM_regwrite !== 1'b0 || ex_stall !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL reset_mid_mul_after: got %0d bad cycles want 0", bad);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    MEM_WB_regwrite = 1'b0; MEM_WB_rd = 5'd0; MEM_WB_wbdata = 32'h0;
    drive(0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 4'd0, 0, 0, 0);
    #12;
    test_reset();
    test_add();
    test_forward();
    test_store();
    test_alu();
    test_back_to_back();
    test_flush();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
